stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Run/stop/clear/lap controller for the stopwatch time base.
- Owns a gated prescaler on the 25 MHz clock that produces a 100 Hz tick while running.
- Keeps BCD minutes:seconds:centiseconds and accepts commands through a valid/ready handshake from the button/Ethernet command path.
- Outputs drive the display mux and the lap/report logic.

Parameters:
- CLK_HZ, 25000000, input clock frequency in Hz.
- TICK_HZ, 100, time-base resolution (centiseconds); CLK_HZ/TICK_HZ must be an integer ≥ 2.
- PRE_W, 18, prescaler width; must satisfy 2^PRE_W > CLK_HZ/TICK_HZ.

Ports:
- twentyFive_mhz_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_op  in  2  0=START, 1=STOP, 2=CLEAR, 3=LAP.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- running  out  1  high in RUNNING state.
- tick  out  1  one-cycle strobe per elapsed centisecond.
- cs_bcd  out  8  centiseconds, 2 BCD digits, 00-99.
- sec_bcd  out  8  seconds, 2 BCD digits, 00-59.
- min_bcd  out  8  minutes, 2 BCD digits, 00-59.
- lap_valid  out  1  lap snapshot available.
- lap_time  out  24  {min,sec,cs} snapshot.
- lap_ack  in  1  consumer takes lap.
- overflow  out  1  sticky, set at 59:59.99 saturation.

Behaviour:
- Reset: all outputs 0, time 00:00.00, prescaler 0, state IDLE, cmd_ready=1. Reset overrides everything, including mid-command and mid-tick.
- Synchronous design: a single clock with synchronous, active-high reset. The clock is twentyFive_mhz_clk and the reset is reset.
- States: IDLE, RUNNING, STOPPED. The `running` output is registered and equals (state==RUNNING).
- Prescaler:
  - Counts only in RUNNING, 0..DIV-1 where DIV=CLK_HZ/TICK_HZ. It holds its value in STOPPED, so resume keeps the sub-tick phase.
  - Terminal count DIV-1 wraps to 0 and asserts `tick` for exactly that one cycle.
  - First tick after START from IDLE occurs DIV cycles after the accept cycle.
- Time increment on tick: BCD ripple cs→sec→min.
  - cs 99→00 carries into sec.
  - sec 59→00 carries into min.
  - At 59:59.99 a further tick does not wrap: time saturates, overflow=1, state→STOPPED.
- Commands: accepted only on cmd_valid & cmd_ready.
  - START: IDLE/STOPPED→RUNNING. Ignored (consumed) in RUNNING. Ignored while overflow=1.
  - STOP: RUNNING→STOPPED. Otherwise a no-op.
  - CLEAR: any state→IDLE. Zeroes time, prescaler and overflow. Does not affect a pending lap.
  - LAP: loads lap_time with the current pre-increment time value, sets lap_valid. Allowed in any state.
- Handshake:
  - cmd_ready = !lap_valid, registered. While a lap is pending, no command of any kind is accepted.
  - lap_valid stays high until the cycle lap_ack=1, then clears the next cycle. lap_ack while lap_valid=0 is ignored.
- Simultaneous events:
  - tick + STOP in the same cycle: the tick is applied, then STOPPED. Displayed time includes that centisecond.
  - tick + CLEAR: CLEAR wins; time = 0.
  - tick + LAP: the snapshot takes the value before the increment.
  - tick causing saturation + START: overflow/STOPPED wins.
- Widths: BCD digits never exceed 9. Prescaler compare uses a PRE_W-bit constant.

Decomposition:
- Shared package stopwatch_pkg holds:
  - cmd opcode constants CMD_START/STOP/CLEAR/LAP;
  - state encoding;
  - BCD limit constants (9, 5);
  - the lap_time field layout.
- One natural sub-module: bcd_time_counter, holding the three 2-digit BCD registers with inc, clr and saturate/overflow out.
- stopwatch_ctrl keeps the FSM, prescaler and handshake.

Test Plan:
All scenarios use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset then START: tick first pulses 10 cycles after accept, then every 10. After 150 cycles time = 00:00.15 and running=1.
- START, run 57 cycles, STOP, idle 100 cycles, START: time holds 00:00.05 while stopped. Next tick arrives 3 cycles after resume (phase kept), giving 00:00.06.
- Preload 00:59.99 by running, one tick → 01:00.00. Preload 59:59.99, one tick → time stays 59:59.99, overflow=1, running=0, and a following START is ignored.
- LAP at 00:00.42 → lap_valid=1, lap_time=0x000042, cmd_ready=0. A STOP presented is not accepted until lap_ack. After ack, cmd_ready=1 next cycle and STOP is then accepted.
- CLEAR issued in the same cycle as a tick at 00:00.09 → time 00:00.00, state IDLE, prescaler 0, overflow cleared.
- Assert reset mid-RUNNING with lap pending → all outputs 0 and cmd_ready=1 on the next cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time base: command opcodes, FSM
// state encoding, BCD digit limits and the {min,sec,cs} time layout.
package stopwatch_pkg;

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;
    localparam logic [1:0] CMD_LAP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
    } state_t;

    // Largest units digit, and largest tens digit for sexagesimal fields.
    localparam logic [3:0] BCD_MAX_UNITS   = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS_60 = 4'd5;

    // Layout of the time value and of the lap snapshot: {min, sec, cs}.
    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] cs;
    } time_t;

    localparam time_t TIME_MAX = '{
        min: {BCD_MAX_TENS_60, BCD_MAX_UNITS},
        sec: {BCD_MAX_TENS_60, BCD_MAX_UNITS},
        cs:  {BCD_MAX_UNITS,   BCD_MAX_UNITS}
    };

    // Next value of a 2-digit BCD field; wraps to 00 after {tens_max,9}.
    function automatic logic [7:0] bcd2_next(input logic [7:0] v,
                                             input logic [3:0] tens_max);
        logic [7:0] r;
        if (v[3:0] != BCD_MAX_UNITS)
            r = {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != tens_max)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_time_counter.sv
// Three 2-digit BCD registers (cs, sec, min) with ripple carry, clear,
// and saturation at 59:59.99 with a sticky overflow flag.
module bcd_time_counter
    import stopwatch_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_inc,
    input  logic  i_clr,
    output time_t o_time,
    output logic  o_at_max,
    output logic  o_overflow
);

    time_t r_time;
    time_t w_time_nxt;
    logic  r_overflow;
    logic  w_at_max;
    logic  w_cs_wrap;
    logic  w_sec_wrap;

    assign w_at_max   = (r_time == TIME_MAX);
    assign w_cs_wrap  = (r_time.cs  == {BCD_MAX_UNITS, BCD_MAX_UNITS});
    assign w_sec_wrap = (r_time.sec == {BCD_MAX_TENS_60, BCD_MAX_UNITS});

    // Next time value: clear beats increment; increment at the max holds.
    always_comb begin
        w_time_nxt = r_time;
        if (i_clr) begin
            w_time_nxt = '0;
        end else if (i_inc && !w_at_max) begin
            w_time_nxt.cs = bcd2_next(r_time.cs, BCD_MAX_UNITS);
            if (w_cs_wrap) begin
                w_time_nxt.sec = bcd2_next(r_time.sec, BCD_MAX_TENS_60);
                if (w_sec_wrap)
                    w_time_nxt.min = bcd2_next(r_time.min, BCD_MAX_TENS_60);
            end
        end
    end

    // Time registers and sticky overflow, set by a tick arriving at the max.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_time     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_time <= w_time_nxt;
            if (i_clr)
                r_overflow <= 1'b0;
            else if (i_inc && w_at_max)
                r_overflow <= 1'b1;
        end
    end

    assign o_time     = r_time;
    assign o_at_max   = w_at_max;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/stop/clear/lap controller: FSM, gated prescaler producing
// the centisecond tick, command handshake and lap snapshot.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 100,
    parameter int PRE_W   = 18
) (
    input  logic        twentyFive_mhz_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    output logic        running,
    output logic        tick,
    output logic [7:0]  cs_bcd,
    output logic [7:0]  sec_bcd,
    output logic [7:0]  min_bcd,
    output logic        lap_valid,
    output logic [23:0] lap_time,
    input  logic        lap_ack,
    output logic        overflow
);

    localparam int              DIV      = CLK_HZ / TICK_HZ;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PRE_W-1:0] r_pre;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             r_tick;
    logic             r_running;
    logic             r_cmd_ready;
    logic             r_lap_valid;
    logic             w_lap_valid_nxt;
    time_t            r_lap_time;
    time_t            w_time;
    logic             w_at_max;
    logic             w_overflow;
    logic             w_fire;
    logic             w_clr;
    logic             w_lap_fire;
    logic             w_tick_evt;
    logic             w_sat;

    assign w_fire     = cmd_valid && r_cmd_ready;
    assign w_clr      = w_fire && (cmd_op == CMD_CLEAR);
    assign w_lap_fire = w_fire && (cmd_op == CMD_LAP);
    assign w_tick_evt = (r_state == ST_RUNNING) && (r_pre == PRE_LAST);
    assign w_sat      = w_tick_evt && w_at_max;

    bcd_time_counter u_time (
        .i_clk      (twentyFive_mhz_clk),
        .i_rst      (reset),
        .i_inc      (w_tick_evt),
        .i_clr      (w_clr),
        .o_time     (w_time),
        .o_at_max   (w_at_max),
        .o_overflow (w_overflow)
    );

    // Next state and prescaler: commands, then saturation, then CLEAR wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        if (r_state == ST_RUNNING)
            w_pre_nxt = w_tick_evt ? '0 : r_pre + PRE_W'(1);
        if (w_fire) begin
            case (cmd_op)
                CMD_START: if (r_state != ST_RUNNING && !w_overflow)
                               w_state_nxt = ST_RUNNING;
                CMD_STOP:  if (r_state == ST_RUNNING)
                               w_state_nxt = ST_STOPPED;
                CMD_CLEAR: w_state_nxt = ST_IDLE;
                default:   ;
            endcase
        end
        if (w_sat)
            w_state_nxt = ST_STOPPED;
        if (w_clr) begin
            w_state_nxt = ST_IDLE;
            w_pre_nxt   = '0;
        end
    end

    // Lap pending flag: set by LAP, cleared the cycle after lap_ack.
    always_comb begin
        w_lap_valid_nxt = r_lap_valid;
        if (w_lap_fire)
            w_lap_valid_nxt = 1'b1;
        else if (r_lap_valid && lap_ack)
            w_lap_valid_nxt = 1'b0;
    end

    // State, prescaler and registered status strobes.
    always_ff @(posedge twentyFive_mhz_clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_pre     <= '0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_tick    <= w_tick_evt && !w_clr;
            r_running <= (w_state_nxt == ST_RUNNING);
        end
    end

    // Lap snapshot (pre-increment time) and handshake ready.
    always_ff @(posedge twentyFive_mhz_clk) begin
        if (reset) begin
            r_lap_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_lap_time  <= '0;
        end else begin
            r_lap_valid <= w_lap_valid_nxt;
            r_cmd_ready <= !w_lap_valid_nxt;
            if (w_lap_fire)
                r_lap_time <= w_time;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign running   = r_running;
    assign tick      = r_tick;
    assign cs_bcd    = w_time.cs;
    assign sec_bcd   = w_time.sec;
    assign min_bcd   = w_time.min;
    assign lap_valid = r_lap_valid;
    assign lap_time  = r_lap_time;
    assign overflow  = w_overflow;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV = 1000/100 = 10.
// Inputs are driven and outputs sampled on the falling edge.
module tb_stopwatch_ctrl;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_CLEAR = 2'd2;
    localparam logic [1:0] OP_LAP   = 2'd3;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op    = 2'd0;
    logic        lap_ack   = 1'b0;
    logic        cmd_ready;
    logic        running;
    logic        tick;
    logic [7:0]  cs_bcd;
    logic [7:0]  sec_bcd;
    logic [7:0]  min_bcd;
    logic        lap_valid;
    logic [23:0] lap_time;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(
        .CLK_HZ  (1000),
        .TICK_HZ (100),
        .PRE_W   (18)
    ) dut (
        .twentyFive_mhz_clk (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_op             (cmd_op),
        .cmd_ready          (cmd_ready),
        .running            (running),
        .tick               (tick),
        .cs_bcd             (cs_bcd),
        .sec_bcd            (sec_bcd),
        .min_bcd            (min_bcd),
        .lap_valid          (lap_valid),
        .lap_time           (lap_time),
        .lap_ack            (lap_ack),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one command for a single cycle; caller ensures cmd_ready=1.
    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    function automatic logic [31:0] now_t();
        return {8'h00, min_bcd, sec_bcd, cs_bcd};
    endfunction

    initial begin
        // Reset state
        cycles(3);
        check_eq("rst_ready",   {31'd0, cmd_ready}, 32'd1);
        check_eq("rst_running", {31'd0, running},   32'd0);
        check_eq("rst_tick",    {31'd0, tick},      32'd0);
        check_eq("rst_time",    now_t(),            32'h000000);
        check_eq("rst_lapv",    {31'd0, lap_valid}, 32'd0);
        check_eq("rst_lapt",    {8'd0, lap_time},   32'h000000);
        check_eq("rst_ovf",     {31'd0, overflow},  32'd0);
        reset = 1'b0;
        cycles(1);

        // START: first tick 10 cycles after accept, then every 10
        send_cmd(OP_START);
        check_eq("start_running", {31'd0, running}, 32'd1);
        cycles(9);
        check_eq("t9_no_tick", {31'd0, tick}, 32'd0);
        check_eq("t9_time",    now_t(),       32'h000000);
        cycles(1);
        check_eq("t10_tick", {31'd0, tick}, 32'd1);
        check_eq("t10_time", now_t(),       32'h000001);
        cycles(1);
        check_eq("t11_no_tick", {31'd0, tick}, 32'd0);
        cycles(9);
        check_eq("t20_tick", {31'd0, tick}, 32'd1);
        check_eq("t20_time", now_t(),       32'h000002);
        cycles(130);
        check_eq("t150_time",    now_t(),           32'h000015);
        check_eq("t150_running", {31'd0, running}, 32'd1);

        // Stop after 57 running cycles, resume keeps the sub-tick phase
        send_cmd(OP_CLEAR);
        check_eq("clr_time",    now_t(),           32'h000000);
        check_eq("clr_running", {31'd0, running}, 32'd0);
        send_cmd(OP_START);
        cycles(56);
        send_cmd(OP_STOP);
        check_eq("stop_running", {31'd0, running}, 32'd0);
        check_eq("stop_time",    now_t(),           32'h000005);
        cycles(100);
        check_eq("stopped_hold", now_t(), 32'h000005);
        send_cmd(OP_START);
        cycles(2);
        check_eq("resume_no_tick", {31'd0, tick}, 32'd0);
        check_eq("resume_t2",      now_t(),       32'h000005);
        cycles(1);
        check_eq("resume_tick", {31'd0, tick}, 32'd1);
        check_eq("resume_time", now_t(),       32'h000006);

        // Seconds-to-minutes carry from a preloaded 00:59.99
        send_cmd(OP_CLEAR);
        force dut.u_time.r_time = 24'h005999;
        cycles(2);
        release dut.u_time.r_time;
        check_eq("preload_a", now_t(), 32'h005999);
        send_cmd(OP_START);
        cycles(9);
        check_eq("carry_before", now_t(), 32'h005999);
        cycles(1);
        check_eq("carry_min", now_t(), 32'h010000);

        // Saturation at 59:59.99, then START is ignored
        send_cmd(OP_STOP);
        send_cmd(OP_CLEAR);
        force dut.u_time.r_time = 24'h595999;
        cycles(2);
        release dut.u_time.r_time;
        send_cmd(OP_START);
        cycles(10);
        check_eq("sat_time",    now_t(),           32'h595999);
        check_eq("sat_ovf",     {31'd0, overflow}, 32'd1);
        check_eq("sat_running", {31'd0, running},  32'd0);
        send_cmd(OP_START);
        cycles(20);
        check_eq("sat_start_ign", {31'd0, running}, 32'd0);
        check_eq("sat_hold",      now_t(),           32'h595999);

        // CLEAR drops overflow; LAP at 00:00.42 blocks further commands
        send_cmd(OP_CLEAR);
        check_eq("clr_ovf",  {31'd0, overflow}, 32'd0);
        check_eq("clr_time2", now_t(),          32'h000000);
        send_cmd(OP_START);
        cycles(420);
        check_eq("lap_pre_time", now_t(), 32'h000042);
        send_cmd(OP_LAP);
        check_eq("lap_valid", {31'd0, lap_valid}, 32'd1);
        check_eq("lap_time",  {8'd0, lap_time},   32'h000042);
        check_eq("lap_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        cycles(5);
        check_eq("lap_blocks_stop", {31'd0, running},   32'd1);
        check_eq("lap_still_valid", {31'd0, lap_valid}, 32'd1);
        lap_ack = 1'b1;
        cycles(1);
        lap_ack = 1'b0;
        check_eq("ack_lapv",    {31'd0, lap_valid}, 32'd0);
        check_eq("ack_ready",   {31'd0, cmd_ready}, 32'd1);
        check_eq("ack_running", {31'd0, running},   32'd1);
        cycles(1);
        cmd_valid = 1'b0;
        check_eq("stop_after_ack", {31'd0, running}, 32'd0);

        // STOP coinciding with a tick: the centisecond is counted
        send_cmd(OP_CLEAR);
        send_cmd(OP_START);
        cycles(9);
        send_cmd(OP_STOP);
        check_eq("tickstop_time",    now_t(),           32'h000001);
        check_eq("tickstop_running", {31'd0, running}, 32'd0);

        // CLEAR coinciding with a tick at 00:00.09: clear wins, phase reset
        send_cmd(OP_CLEAR);
        send_cmd(OP_START);
        cycles(99);
        check_eq("tickclr_pre", now_t(), 32'h000009);
        send_cmd(OP_CLEAR);
        check_eq("tickclr_time",    now_t(),           32'h000000);
        check_eq("tickclr_running", {31'd0, running}, 32'd0);
        send_cmd(OP_START);
        cycles(9);
        check_eq("tickclr_pre0_a", {31'd0, tick}, 32'd0);
        cycles(1);
        check_eq("tickclr_pre0_b", {31'd0, tick}, 32'd1);
        check_eq("tickclr_pre0_t", now_t(),       32'h000001);

        // Reset while running with a lap pending
        send_cmd(OP_LAP);
        check_eq("pre_rst_lapv", {31'd0, lap_valid}, 32'd1);
        reset = 1'b1;
        cycles(1);
        check_eq("mrst_running", {31'd0, running},   32'd0);
        check_eq("mrst_tick",    {31'd0, tick},      32'd0);
        check_eq("mrst_time",    now_t(),            32'h000000);
        check_eq("mrst_lapv",    {31'd0, lap_valid}, 32'd0);
        check_eq("mrst_lapt",    {8'd0, lap_time},   32'h000000);
        check_eq("mrst_ready",   {31'd0, cmd_ready}, 32'd1);
        check_eq("mrst_ovf",     {31'd0, overflow},  32'd0);
        reset = 1'b0;
        cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
